// File: rtl/data_mem_stage_pkg.sv
// Shared CPU package for the data-memory stage: FSM state encoding and the
// word-alignment mask used to detect misaligned accesses.
package data_mem_stage_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } mem_state_e;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] MisalignMask = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i and holds at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/data_mem_stage.sv
// MEM pipeline stage: issues word loads/stores to data memory, stalls upstream
// until the access is acknowledged, and registers results for the MEM/WB buffer.
module data_mem_stage
  import data_mem_stage_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [2:0]             Op_i,
  input  logic                   mem_read_i,
  input  logic                   mem_write_i,
  input  logic [31:0]            alu_result_i,
  input  logic [31:0]            write_data_i,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [31:0]            dmem_addr_o,
  output logic [31:0]            dmem_wdata_o,
  input  logic                   dmem_ack_i,
  input  logic [31:0]            dmem_rdata_i,
  output logic                   stall_o,
  output logic [31:0]            alu_result_o,
  output logic [31:0]            memory_data_o,
  output logic [2:0]             Op_o,
  output logic                   valid_o,
  output logic                   misalign_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  lop_q, lop_d;
  logic        valid_q, valid_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [2:0]  op_out_q, op_out_d;
  logic        misalign_q, misalign_d;

  logic mem_op;
  logic aligned;

  assign mem_op  = valid_i & (mem_read_i | mem_write_i);
  assign aligned = (alu_result_i[1:0] & MisalignMask) == 2'b00;

  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    lop_d      = lop_q;
    valid_d    = 1'b0;
    alu_out_d  = alu_out_q;
    mem_data_d = mem_data_q;
    op_out_d   = op_out_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op && aligned) begin
          stall_o = 1'b1;
          addr_d  = alu_result_i;
          wdata_d = write_data_i;
          // Both flags set resolves to a store.
          we_d    = mem_write_i;
          lop_d   = Op_i;
          state_d = StWait;
        end else if (valid_i) begin
          valid_d    = 1'b1;
          alu_out_d  = alu_result_i;
          mem_data_d = '0;
          op_out_d   = Op_i;
          misalign_d = mem_op;
        end
      end
      StWait: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) begin
          state_d    = StIdle;
          valid_d    = 1'b1;
          alu_out_d  = addr_q;
          mem_data_d = we_q ? '0 : dmem_rdata_i;
          op_out_d   = lop_q;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      lop_q      <= '0;
      valid_q    <= 1'b0;
      alu_out_q  <= '0;
      mem_data_q <= '0;
      op_out_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      lop_q      <= lop_d;
      valid_q    <= valid_d;
      alu_out_q  <= alu_out_d;
      mem_data_q <= mem_data_d;
      op_out_q   <= op_out_d;
      misalign_q <= misalign_d;
    end
  end

  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_wdata_o  = wdata_q;
  assign valid_o       = valid_q;
  assign alu_result_o  = alu_out_q;
  assign memory_data_o = mem_data_q;
  assign Op_o          = op_out_q;
  assign misalign_o    = misalign_q;

  sat_counter #(
    .Width(STALL_CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (stall_o),
    .count_o(stall_cnt_o)
  );

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: results are scoreboarded on issue and
// compared whenever valid_o is seen.
module tb_data_mem_stage;

  localparam int unsigned CW = 8;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [2:0]  op;
    logic        mis;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic [2:0]    Op_i = '0;
  logic          mem_read_i = 1'b0;
  logic          mem_write_i = 1'b0;
  logic [31:0]   alu_result_i = '0;
  logic [31:0]   write_data_i = '0;
  logic          dmem_req_o, dmem_we_o;
  logic [31:0]   dmem_addr_o, dmem_wdata_o;
  logic          dmem_ack_i = 1'b0;
  logic [31:0]   dmem_rdata_i = '0;
  logic          stall_o;
  logic [31:0]   alu_result_o, memory_data_o;
  logic [2:0]    Op_o;
  logic          valid_o, misalign_o;
  logic [CW-1:0] stall_cnt_o;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  data_mem_stage #(
    .STALL_CNT_W(CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .Op_i         (Op_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .alu_result_i (alu_result_i),
    .write_data_i (write_data_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .alu_result_o (alu_result_o),
    .memory_data_o(memory_data_o),
    .Op_o         (Op_o),
    .valid_o      (valid_o),
    .misalign_o   (misalign_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] alu, input logic [31:0] wd);
    valid_i      = v;
    mem_read_i   = rd;
    mem_write_i  = wr;
    Op_i         = op;
    alu_result_i = alu;
    write_data_i = wd;
  endtask

  task automatic push(input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] op,
                      input logic mis);
    exp_t e;
    e.alu = alu;
    e.mem = mem;
    e.op  = op;
    e.mis = mis;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every valid result must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", {31'b0, valid_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_alu_result", alu_result_o, e.alu);
        check_eq("sb_memory_data", memory_data_o, e.mem);
        check_eq("sb_op", {29'b0, Op_o}, {29'b0, e.op});
        check_eq("sb_misalign", {31'b0, misalign_o}, {31'b0, e.mis});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check_eq("rst_valid", {31'b0, valid_o}, 32'd0);
    check_eq("rst_req", {31'b0, dmem_req_o}, 32'd0);
    check_eq("rst_alu", alu_result_o, 32'd0);
    check_eq("rst_cnt", {24'b0, stall_cnt_o}, 32'd0);
    step();
    rst_i = 1'b0;
    step();

    // ALU op, latency 1, no stall
    drive(1'b1, 1'b0, 1'b0, 3'b101, 32'h10, 32'h0);
    push(32'h10, 32'h0, 3'b101, 1'b0);
    @(negedge clk_i);
    check_eq("alu_stall", {31'b0, stall_o}, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk_i);
    check_eq("alu_valid", {31'b0, valid_o}, 32'd1);
    step();
    @(negedge clk_i);
    check_eq("idle_valid_low", {31'b0, valid_o}, 32'd0);
    check_eq("idle_alu_hold", alu_result_o, 32'h10);

    // Load at 0x100, ack after 3 WAIT cycles
    step();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    push(32'h100, 32'hDEAD_BEEF, 3'b010, 1'b0);
    @(negedge clk_i);
    check_eq("ld_accept_stall", {31'b0, stall_o}, 32'd1);
    check_eq("ld_accept_req", {31'b0, dmem_req_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk_i);
      check_eq("ld_wait_req", {31'b0, dmem_req_o}, 32'd1);
      check_eq("ld_wait_addr", dmem_addr_o, 32'h100);
      check_eq("ld_wait_stall", {31'b0, stall_o}, 32'd1);
      check_eq("ld_wait_valid", {31'b0, valid_o}, 32'd0);
    end
    step();
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check_eq("ld_ack_stall", {31'b0, stall_o}, 32'd0);
    step();
    dmem_ack_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk_i);
    check_eq("ld_valid", {31'b0, valid_o}, 32'd1);
    check_eq("ld_stall_cnt", {24'b0, stall_cnt_o}, 32'd4);
    check_eq("ld_idle_req", {31'b0, dmem_req_o}, 32'd0);

    // Store at 0x104, immediate ack
    step();
    drive(1'b1, 1'b0, 1'b1, 3'b011, 32'h104, 32'h1234_5678);
    push(32'h104, 32'h0, 3'b011, 1'b0);
    step();
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check_eq("st_we", {31'b0, dmem_we_o}, 32'd1);
    check_eq("st_addr", dmem_addr_o, 32'h104);
    check_eq("st_wdata", dmem_wdata_o, 32'h1234_5678);
    check_eq("st_ack_stall", {31'b0, stall_o}, 32'd0);
    step();
    dmem_ack_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk_i);
    check_eq("st_valid", {31'b0, valid_o}, 32'd1);
    check_eq("st_stall_cnt", {24'b0, stall_cnt_o}, 32'd5);

    // Both flags set behaves as a store
    step();
    drive(1'b1, 1'b1, 1'b1, 3'b110, 32'h108, 32'hCAFE_F00D);
    push(32'h108, 32'h0, 3'b110, 1'b0);
    step();
    dmem_ack_i = 1'b1;
    @(negedge clk_i);
    check_eq("rw_we", {31'b0, dmem_we_o}, 32'd1);
    step();
    dmem_ack_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    // Misaligned load at 0x102, ack in IDLE must be ignored
    step();
    drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
    dmem_ack_i = 1'b1;
    push(32'h102, 32'h0, 3'b001, 1'b1);
    @(negedge clk_i);
    check_eq("mis_req", {31'b0, dmem_req_o}, 32'd0);
    check_eq("mis_stall", {31'b0, stall_o}, 32'd0);
    step();
    dmem_ack_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk_i);
    check_eq("mis_valid", {31'b0, valid_o}, 32'd1);
    check_eq("mis_req_after", {31'b0, dmem_req_o}, 32'd0);

    // Reset mid-WAIT abandons the access
    step();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    step();
    @(negedge clk_i);
    check_eq("rw_wait_req", {31'b0, dmem_req_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check_eq("rst_req_drop", {31'b0, dmem_req_o}, 32'd0);
    check_eq("rst_cnt_zero", {24'b0, stall_cnt_o}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();
    rst_i = 1'b0;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    check_eq("rst_ack_req", {31'b0, dmem_req_o}, 32'd0);
    check_eq("rst_ack_stall", {31'b0, stall_o}, 32'd0);
    step();
    dmem_ack_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_no_valid", {31'b0, valid_o}, 32'd0);
    check_eq("rst_cnt_after", {24'b0, stall_cnt_o}, 32'd0);

    // Saturation: load held in WAIT for 2^CW+5 stall cycles
    step();
    drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h300, 32'h0);
    push(32'h300, 32'h0BAD_F00D, 3'b100, 1'b0);
    for (int i = 1; i < (1 << CW) + 5; i++) begin
      step();
      if (i == (1 << CW) - 2) begin
        check_eq("sat_progress", {24'b0, stall_cnt_o}, (1 << CW) - 2);
      end
    end
    @(negedge clk_i);
    check_eq("sat_still_stall", {31'b0, stall_o}, 32'd1);
    step();
    check_eq("sat_hold", {24'b0, stall_cnt_o}, (1 << CW) - 1);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h0BAD_F00D;
    step();
    dmem_ack_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk_i);
    check_eq("sat_valid", {31'b0, valid_o}, 32'd1);
    check_eq("sat_final", {24'b0, stall_cnt_o}, (1 << CW) - 1);
    step();
    step();
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 Parameter STALL_CNT_W, default 16: width of the stall statistics counter.
REQ-002 Port clk_i input 1: single clock; all state updates on posedge clk_i.
REQ-003 Port rst_i input 1: reset, asynchronous, active-high.
REQ-004 Port valid_i input 1: upstream (EX/MEM) holds a valid instruction.
REQ-005 Port Op_i input 3: writeback control code, passed through unchanged.
REQ-006 Port mem_read_i / mem_write_i input 1 each: load / store request.
REQ-007 Port alu_result_i input 32: ALU result; also the byte address of the memory access.
REQ-008 Port write_data_i input 32: store data.
REQ-009 Ports dmem_req_o, dmem_we_o output 1; dmem_addr_o, dmem_wdata_o output 32: data-memory request bus.
REQ-010 Ports dmem_ack_i input 1, dmem_rdata_i input 32: memory completion and load data.
REQ-011 Port stall_o output 1: upstream SHALL hold all inputs while high.
REQ-012 Ports alu_result_o, memory_data_o output 32; Op_o output 3; valid_o output 1: registered results to the MEM/WB buffer.
REQ-013 Port misalign_o output 1: result is from a misaligned access that was suppressed.
REQ-014 Port stall_cnt_o output STALL_CNT_W: saturating count of stall cycles.

Function
REQ-015 FSM SHALL have exactly two states, IDLE and WAIT.
REQ-016 Memory op = valid_i & (mem_read_i | mem_write_i); both flags set SHALL be treated as a store.
REQ-017 Aligned memory op in IDLE: latch address, wdata and we; go to WAIT next cycle; stall_o=1 combinationally in that IDLE cycle.
REQ-018 In WAIT: dmem_req_o=1, dmem_addr_o/dmem_wdata_o/dmem_we_o driven from the latched values and stable until ack; stall_o=1 until the ack cycle.
REQ-019 In WAIT with dmem_ack_i=1: stall_o=0 that cycle; next edge goes to IDLE with valid_o=1, alu_result_o=latched address, memory_data_o=dmem_rdata_i for loads or 0 for stores, Op_o=latched Op.
REQ-020 Non-memory valid op in IDLE: stall_o=0; next cycle valid_o=1, alu_result_o=alu_result_i, memory_data_o=0, Op_o=Op_i (latency 1).
REQ-021 Misaligned memory op (alu_result_i[1:0]!=0) in IDLE: no request, stall_o=0; next cycle valid_o=1, misalign_o=1, memory_data_o=0.
REQ-022 misalign_o SHALL be 0 on every other valid result.
REQ-023 valid_i=0 in IDLE: valid_o=0 next cycle; data outputs hold previous values.
REQ-024 valid_o SHALL be 0 on every cycle following a WAIT cycle without ack.
REQ-025 dmem_ack_i in IDLE SHALL be ignored; dmem_req_o SHALL be 0 in IDLE.
REQ-026 Memory-op latency: valid_o rises exactly one cycle after the ack cycle (minimum 2 cycles from acceptance).
REQ-027 stall_cnt_o SHALL increment on every cycle with stall_o=1 and saturate at all-ones without wrapping.

Reset
REQ-028 rst_i=1 SHALL immediately force IDLE, dmem_req_o=0, valid_o=0, misalign_o=0, and zero all data outputs, latches and stall_cnt_o.
REQ-029 Reset during WAIT SHALL abandon the access; a later dmem_ack_i SHALL be ignored.

Structure
REQ-030 State encoding and the misalignment mask constant SHALL live in the shared CPU package.
REQ-031 The saturating stall counter SHALL be one sub-module, sat_counter; everything else stays flat.

Verification
REQ-032 ALU op valid_i=1, Op_i=3'b101, alu_result_i=0x0000_0010 -> next cycle valid_o=1, alu_result_o=0x10, memory_data_o=0, stall_o never high.
REQ-033 Load at 0x100, ack after 3 WAIT cycles with rdata=0xDEAD_BEEF -> stall_o high for 4 cycles, valid_o=1 with memory_data_o=0xDEADBEEF the cycle after ack, stall_cnt_o=4.
REQ-034 Store at 0x104 with data 0x1234_5678, immediate ack -> dmem_we_o=1, addr 0x104, wdata 0x12345678 in WAIT; valid_o=1 with memory_data_o=0 two cycles after acceptance.
REQ-035 Load at 0x102 -> dmem_req_o stays 0, next cycle valid_o=1, misalign_o=1, memory_data_o=0.
REQ-036 rst_i pulsed mid-WAIT, then ack pulsed -> dmem_req_o drops immediately, no valid_o, FSM in IDLE, stall_cnt_o=0.
REQ-037 Force 2^STALL_CNT_W+5 stall cycles -> stall_cnt_o holds all-ones.
